serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor, diff = a - b - bin,
//               one bit per clock, LSB first, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int                CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]     C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic               brw_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               ovf_q;
    logic               done_q;

    logic               w_d;
    logic               w_brw_d;
    logic [WIDTH-1:0]   w_res_d;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        w_d     = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        w_brw_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        w_res_d = {w_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        brw_q   <= bin_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= w_res_d;
                    brw_q  <= w_brw_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        // brw_q here is the borrow entering the MSB.
                        diff_q  <= w_res_d;
                        bout_q  <= w_brw_d;
                        ovf_q   <= w_brw_d ^ brw_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and random self-checking bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] a_i = '0;
    logic [3:0] b_i = '0;
    logic       bin_i = 1'b0;
    logic       busy_o;
    logic       done_o;
    logic [3:0] diff_o;
    logic       bout_o;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .bout_o  (bout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    // Runs one operation; lat = index of the first edge that samples done high
    // (E0 = accepting edge); holds = cycles where diff moved before done.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output int lat, output int holds);
        logic [3:0] prev;
        prev = diff_o;
        @(negedge clk);
        start_i = 1'b1; a_i = a; b_i = b; bin_i = bin;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; a_i = ~a; b_i = ~b; bin_i = ~bin;
        lat = 0;
        holds = 0;
        while (done_o !== 1'b1 && lat < 40) begin
            if (diff_o !== prev) holds++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        lat = lat + 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, diff_o, bout_o, ovf_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy_o, done_o, diff_o, bout_o, ovf_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [3:0] va [4] = '{4'hA, 4'h3, 4'h0, 4'hF};
        logic [3:0] vb [4] = '{4'h5, 4'h7, 4'h0, 4'hF};
        logic       vi [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] ed [4] = '{4'h5, 4'hB, 4'hF, 4'h0};
        logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       eo [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int lat, holds;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vi[i], lat, holds);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d edges, want 5", i, lat);
            end
            checks++;
            if ({diff_o, bout_o, ovf_o} !== {ed[i], eb[i], eo[i]}) begin
                errors++;
                $display("FAIL vec%0d_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                         i, diff_o, bout_o, ovf_o, ed[i], eb[i], eo[i]);
            end
            checks++;
            if (holds !== 0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_hold: got %0d early diff changes busy=%b, want 0 and busy=1",
                         i, holds, busy_o);
            end
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_done_pulse: got done=%b busy=%b after pulse, want 0 0",
                         i, done_o, busy_o);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [3:0] got = 4'h0;
        @(negedge clk);
        start_i = 1'b1; a_i = 4'd2; b_i = 4'd1; bin_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b1; a_i = 4'd9;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done_o === 1'b1) begin
                ndone++;
                got = diff_o;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1 || got !== 4'h1) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses diff=%h, want 1 pulse diff=1", ndone, got);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3] = '{4'h6, 4'h1, 4'h7};
        logic [3:0] vb [3] = '{4'h2, 4'h3, 4'h8};
        logic       vi [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] ed [3] = '{4'h4, 4'hE, 4'hE};
        logic       eb [3] = '{1'b0, 1'b1, 1'b1};
        logic       eo [3] = '{1'b0, 1'b0, 1'b1};
        int idx = 0;
        int cyc = 0;
        int last = 0;
        @(negedge clk);
        start_i = 1'b1; a_i = va[0]; b_i = vb[0]; bin_i = vi[0];
        while (idx < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_o === 1'b1) begin
                checks++;
                if ({diff_o, bout_o, ovf_o} !== {ed[idx], eb[idx], eo[idx]}) begin
                    errors++;
                    $display("FAIL b2b%0d_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                             idx, diff_o, bout_o, ovf_o, ed[idx], eb[idx], eo[idx]);
                end
                if (idx > 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++;
                        $display("FAIL b2b%0d_spacing: got %0d edges, want 6", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
                if (idx < 3) begin
                    a_i = va[idx]; b_i = vb[idx]; bin_i = vi[idx];
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        checks++;
        if (idx !== 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results, want 3", idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int ndone = 0;
        int lat, holds;
        @(negedge clk);
        start_i = 1'b1; a_i = 4'd5; b_i = 4'd3; bin_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, diff_o, bout_o, ovf_o} !== 8'h00) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy_o, done_o, diff_o, bout_o, ovf_o);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done_o === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", ndone);
        end
        do_op(4'd5, 4'd3, 1'b0, lat, holds);
        checks++;
        if (lat !== 5 || {diff_o, bout_o, ovf_o} !== {4'h2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d diff=%h bout=%b ovf=%b, want lat=5 diff=2 bout=0 ovf=0",
                     lat, diff_o, bout_o, ovf_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic       bin;
        logic [4:0] full;
        int         s, lat, holds;
        logic       eovf;
        for (int i = 0; i < 1000; i++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            bin = 1'($urandom_range(0, 1));
            full = {1'b0, a} - {1'b0, b} - {4'b0, bin};
            s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
            eovf = (s < -8) || (s > 7);
            do_op(a, b, bin, lat, holds);
            checks++;
            if (lat !== 5 || {diff_o, bout_o, ovf_o} !== {full[3:0], full[4], eovf}) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h bin=%b: got lat=%0d diff=%h bout=%b ovf=%b, want lat=5 diff=%h bout=%b ovf=%b",
                         i, a, b, bin, lat, diff_o, bout_o, ovf_o, full[3:0], full[4], eovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
